// File: rtl/commit_reclaim.sv
// rtl/commit_reclaim.sv - architectural rename table plus reclaim FIFO returning displaced pregs to the free list
// Optional statistics counters: RECLAIM_STAT_EN
module commit_reclaim #(
  parameter int COMMIT_WIDTH = 2,
  parameter int ARCHREG      = 32,
  parameter int PHYREG       = 64,
  parameter int FIFO_DEPTH   = 8,
  localparam int AW = $clog2(ARCHREG),
  localparam int PW = $clog2(PHYREG),
  localparam int FW = $clog2(FIFO_DEPTH),
  localparam int CW = FW + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [COMMIT_WIDTH-1:0]          commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_wen_i,
  input  logic [COMMIT_WIDTH-1:0][AW-1:0]  commit_areg_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  commit_preg_i,
  output logic                             commit_ready_o,
  output logic [COMMIT_WIDTH-1:0]          free_valid_o,
  output logic [COMMIT_WIDTH-1:0][PW-1:0]  free_preg_o,
  input  logic                             free_ready_i,
  output logic [ARCHREG-1:0][PW-1:0]       arch_rat_o,
`ifdef RECLAIM_STAT_EN
  output logic [31:0]                      reclaim_cnt_o,
  output logic [31:0]                      stall_cnt_o,
`endif
  output logic [CW-1:0]                    fifo_cnt_o
);

  logic [ARCHREG-1:0][PW-1:0]    rat_q, rat_d;
  logic [FIFO_DEPTH-1:0][PW-1:0] fifo_q, fifo_d;
  logic [FW-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [CW-1:0]                 push_n, pop_n;
  logic [COMMIT_WIDTH-1:0]       eff;
  logic [PW-1:0]                 old_preg;
  logic                          ready;

  always_comb begin
    ready    = (cnt_q <= CW'(FIFO_DEPTH - COMMIT_WIDTH));
    rat_d    = rat_q;
    fifo_d   = fifo_q;
    push_n   = '0;
    old_preg = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++)
      eff[i] = commit_valid_i[i] & commit_wen_i[i] & ready & (commit_areg_i[i] != '0);
    // An older slot in the same group writing the same areg displaces the table entry first.
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (eff[i]) begin
        old_preg = rat_q[commit_areg_i[i]];
        for (int j = 0; j < i; j++)
          if (eff[j] && (commit_areg_i[j] == commit_areg_i[i]))
            old_preg = commit_preg_i[j];
        fifo_d[FW'(tail_q + push_n[FW-1:0])] = old_preg;
        push_n = push_n + CW'(1);
      end
    end
    for (int i = 0; i < COMMIT_WIDTH; i++)
      if (eff[i]) rat_d[commit_areg_i[i]] = commit_preg_i[i];
    pop_n  = free_ready_i ? ((cnt_q < CW'(COMMIT_WIDTH)) ? cnt_q : CW'(COMMIT_WIDTH)) : '0;
    cnt_d  = cnt_q + push_n - pop_n;
    head_d = head_q + pop_n[FW-1:0];
    tail_d = tail_q + push_n[FW-1:0];
  end

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      free_valid_o[k] = (cnt_q > CW'(k));
      free_preg_o[k]  = fifo_q[FW'(head_q + FW'(k))];
    end
  end

  assign commit_ready_o = ready;
  assign arch_rat_o     = rat_q;
  assign fifo_cnt_o     = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARCHREG; i++) rat_q[i] <= PW'(i);
      fifo_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      rat_q  <= rat_d;
      fifo_q <= fifo_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef RECLAIM_STAT_EN
  logic [31:0] reclaim_q, stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reclaim_q <= '0;
      stall_q   <= '0;
    end else begin
      reclaim_q <= reclaim_q + 32'(push_n);
      if ((|commit_valid_i) && !ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign reclaim_cnt_o = reclaim_q;
  assign stall_cnt_o   = stall_q;
`endif

endmodule

// File: tb/tb_commit_reclaim.sv
// tb/tb_commit_reclaim.sv - randomized check of commit_reclaim against a sequential-commit reference model
module tb_commit_reclaim;
  localparam int W = 2, AR = 32, PR = 64, D = 8, AW = 5, PW = 6, CW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [W-1:0]         cv, cw;
  logic [W-1:0][AW-1:0] ca;
  logic [W-1:0][PW-1:0] cp;
  logic                 fr;
  logic                 commit_ready;
  logic [W-1:0]         free_valid;
  logic [W-1:0][PW-1:0] free_preg;
  logic [AR-1:0][PW-1:0] arch_rat;
  logic [CW-1:0]        fifo_cnt;
`ifdef RECLAIM_STAT_EN
  logic [31:0]          reclaim_cnt, stall_cnt;
`endif

  commit_reclaim dut (
    .clk(clk), .rst(rst),
    .commit_valid_i(cv), .commit_wen_i(cw), .commit_areg_i(ca), .commit_preg_i(cp),
    .commit_ready_o(commit_ready), .free_valid_o(free_valid), .free_preg_o(free_preg),
    .free_ready_i(fr), .arch_rat_o(arch_rat),
`ifdef RECLAIM_STAT_EN
    .reclaim_cnt_o(reclaim_cnt), .stall_cnt_o(stall_cnt),
`endif
    .fifo_cnt_o(fifo_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int rat_m[AR];
  int q[$];
  int rec_m = 0, stall_m = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < AR; i++) rat_m[i] = i;
    q.delete();
    rec_m = 0;
    stall_m = 0;
  endtask

  // Slots commit one after another: each reads the table as left by the older slot.
  task automatic model_step();
    int rdy, npop;
    rdy  = (q.size() <= D - W);
    npop = fr ? ((q.size() < W) ? q.size() : W) : 0;
    for (int k = 0; k < npop; k++) void'(q.pop_front());
    for (int i = 0; i < W; i++)
      if (cv[i] && cw[i] && rdy != 0 && ca[i] != 0) begin
        q.push_back(rat_m[ca[i]]);
        rat_m[ca[i]] = cp[i];
        rec_m++;
      end
    if (cv != 0 && rdy == 0) stall_m++;
  endtask

  task automatic compare_all();
    logic [AR-1:0][PW-1:0] er;
    logic [W-1:0] ev;
    for (int i = 0; i < AR; i++) er[i] = PW'(rat_m[i]);
    for (int k = 0; k < W; k++) ev[k] = (q.size() > k);
    chk("commit_ready", 256'(commit_ready), 256'(q.size() <= D - W));
    chk("fifo_cnt", 256'(fifo_cnt), 256'(q.size()));
    chk("free_valid", 256'(free_valid), 256'(ev));
    for (int k = 0; k < W; k++)
      if (q.size() > k) chk($sformatf("free_preg%0d", k), 256'(free_preg[k]), 256'(q[k]));
    chk("arch_rat", 256'(arch_rat), 256'(er));
`ifdef RECLAIM_STAT_EN
    chk("reclaim_cnt", 256'(reclaim_cnt), 256'(rec_m));
    chk("stall_cnt", 256'(stall_cnt), 256'(stall_m));
`endif
  endtask

  task automatic cyc(input logic [1:0] v, input logic [1:0] w, input logic [4:0] a0, input logic [5:0] p0,
                     input logic [4:0] a1, input logic [5:0] p1, input logic f);
    cv = v; cw = w; ca[0] = a0; cp[0] = p0; ca[1] = a1; cp[1] = p1; fr = f;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic f);
    cyc(2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, f);
  endtask

  initial begin
    rst = 1'b0; cv = '0; cw = '0; ca = '0; cp = '0; fr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    compare_all();
    chk("rst_rat5", 256'(arch_rat[5]), 256'd5);
    chk("rst_ready", 256'(commit_ready), 256'd1);

    cyc(2'b01, 2'b01, 5'd5, 6'd40, 5'd0, 6'd0, 1'b1);
    chk("single_preg", 256'(free_preg[0]), 256'd5);
    chk("single_rat", 256'(arch_rat[5]), 256'd40);
    idle(1'b1);
    chk("single_drain", 256'(fifo_cnt), 256'd0);

    cyc(2'b11, 2'b11, 5'd7, 6'd41, 5'd7, 6'd42, 1'b0);
    chk("coll_first", 256'(free_preg[0]), 256'd7);
    chk("coll_second", 256'(free_preg[1]), 256'd41);
    chk("coll_rat", 256'(arch_rat[7]), 256'd42);
    idle(1'b1);

    cyc(2'b11, 2'b01, 5'd0, 6'd43, 5'd9, 6'd44, 1'b0);
    chk("areg0_cnt", 256'(fifo_cnt), 256'd0);
    chk("areg0_rat", 256'(arch_rat[0]), 256'd0);

    for (int c = 0; c < 6; c++)
      cyc(2'b11, 2'b11, 5'(2 * c + 10), 6'($urandom_range(0, 63)), 5'(2 * c + 11), 6'($urandom_range(0, 63)), 1'b0);
    chk("bp_full", 256'(fifo_cnt), 256'd8);
    chk("bp_notready", 256'(commit_ready), 256'd0);
    for (int c = 0; c < 5; c++) idle(1'b1);

    for (int c = 0; c < 3000; c++)
      cyc(2'($urandom), 2'($urandom | $urandom), 5'($urandom), 6'($urandom), 5'($urandom_range(0, 3)),
          6'($urandom), ($urandom_range(0, 3) != 0));

    for (int c = 0; c < 20 && q.size() != 0; c++) idle(1'b1);
    chk("pre_rst_empty", 256'(fifo_cnt), 256'd0);
    cyc(2'b11, 2'b11, 5'd3, 6'd50, 5'd4, 6'd51, 1'b0);
    cyc(2'b11, 2'b11, 5'd5, 6'd52, 5'd6, 6'd53, 1'b0);
    chk("pre_rst_cnt4", 256'(fifo_cnt), 256'd4);
    #2 rst = 1'b0;
    #1;
    chk("arst_cnt", 256'(fifo_cnt), 256'd0);
    chk("arst_valid", 256'(free_valid), 256'd0);
    chk("arst_rat3", 256'(arch_rat[3]), 256'd3);
    cv = '0; cw = '0; fr = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    compare_all();
    for (int c = 0; c < 200; c++)
      cyc(2'($urandom), 2'($urandom), 5'($urandom), 6'($urandom), 5'($urandom), 6'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
